reaction_round_fsm: RTL and testbench
=====================================

Name: reaction_round_fsm

Overview:
- Runs one round of the reaction-time test once the main menu FSM selects React (menu code 2'b01). The menu pulses the start input.
- The block waits a pseudo-random delay, then raises "go" and times the player's press in milliseconds. It flags early presses and timeouts.
- Sits directly downstream of the main menu FSM. Feeds the display/score stage with a millisecond result and status flags.

Parameters:
- CLK_HZ, 50000000, system clock frequency; MS_TICKS = CLK_HZ/1000 clocks per millisecond.
- MIN_DELAY_MS, 1000, minimum random wait before go.
- DELAY_BITS, 11, random delay span; the added delay is 0..2^DELAY_BITS-1 ms.
- TIMEOUT_MS, 9999, maximum measurable reaction; fits a 4-digit display.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- iClock  in  1  system clock, rising edge.
- iReset  in  1  asynchronous, active-high reset.
- iStart  in  1  one-cycle pulse from the menu FSM: begin a round.
- iAbort  in  1  return to IDLE (player backs out to the menu).
- iPress  in  1  player button level, already synchronised and debounced.
- oState  out 3  current state encoding, for display muxing.
- oGo     out 1  high in GO only (screen shows "press now").
- oTimeMs out 14  measured reaction in ms, held in RESULT.
- oDone   out 1  one-cycle pulse on entry to RESULT.
- oEarly  out 1  level in RESULT: the press came before go.
- oTimeout out 1  level in RESULT: no press within TIMEOUT_MS.
- oBusy   out 1  high in ARM, WAIT, GO.

Behaviour:
- Reset: state=IDLE, LFSR=LFSR_SEED, all counters 0.
  - Output reset values: oTimeMs=0, oGo=0, oDone=0, oEarly=0, oTimeout=0, oBusy=0.
  - Reset asserted mid-round aborts immediately; no oDone is produced.
- Press event:
  - pressEv = iPress & ~pressQ, where pressQ is iPress registered every cycle (reset 0).
  - Edges only: a button held across the GO entry does not count.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Free-running every cycle from reset. Never zero.
- States: IDLE=0, ARM=1, WAIT=2, GO=3, RESULT=4.
- IDLE:
  - iStart -> ARM.
  - Clears oEarly, oTimeout and oTimeMs.
- ARM (exactly 1 cycle):
  - delayMs <= MIN_DELAY_MS + LFSR[DELAY_BITS-1:0].
  - Clears the ms prescaler and ms counter. -> WAIT.
- WAIT:
  - Prescaler counts 0..MS_TICKS-1; msCnt increments when the prescaler wraps.
  - pressEv -> RESULT with oEarly=1 and oTimeMs=0.
  - Else when msCnt==delayMs -> GO, clearing the prescaler and msCnt.
  - pressEv takes priority over the delay expiry in the same cycle.
- GO:
  - oGo=1; the prescaler and msCnt run as in WAIT.
  - pressEv -> RESULT with oTimeMs <= msCnt (completed ms; truncating).
  - Else when msCnt==TIMEOUT_MS -> RESULT with oTimeout=1 and oTimeMs=TIMEOUT_MS.
  - A press and the timeout in the same cycle count as a valid press.
- RESULT:
  - Outputs held.
  - iStart -> ARM, clearing the flags. A new round starts directly.
  - pressEv is ignored.
- iAbort: highest priority in every state. Next state is IDLE and the flags clear; no oDone.
- iStart: ignored in ARM, WAIT and GO.
- oDone: registered, high for exactly the first cycle that state==RESULT.
- Latency: a pressEv sampled at clock edge k gives state=RESULT after edge k. oDone and oTimeMs are valid in the cycle following edge k.
- Widths:
  - delayMs is 14 bits; the maximum MIN_DELAY_MS+2^DELAY_BITS-1 must be < 2^14 (checked by an elaboration assertion).
  - The prescaler width is clog2(MS_TICKS).

Decomposition:
- Shared package/include holds:
  - the state encodings (also used by the display mux);
  - the menu code constants (Menu=2'b00, React=2'b01, Chimp=2'b10);
  - the 14-bit result width.
- One sub-module: lfsr16 (iClock, iReset, oValue[15:0]), free-running. It is reused later by the chimp test for tile placement.

Test Plan (CLK_HZ=10000 so MS_TICKS=10; MIN_DELAY_MS=5; DELAY_BITS=2; TIMEOUT_MS=20):
- Normal round:
  - Stimulus: reset, iStart pulse, force the LFSR low bits to 2 (delay 7 ms), press 35 clocks after oGo rises.
  - Required: oGo high after 7*10 WAIT clocks plus 1 ARM cycle; oDone single pulse; oTimeMs=3; oEarly=0; oTimeout=0.
- Early press:
  - Stimulus: iStart, press 20 clocks into WAIT.
  - Required: RESULT, oEarly=1, oTimeMs=0, oGo never high, one oDone.
- Timeout:
  - Stimulus: iStart, no press.
  - Required: after 20 ms in GO, oTimeout=1, oTimeMs=20, oDone pulses once.
- Held button:
  - Stimulus: iPress held high from before iStart through GO.
  - Required: no early flag and no result. Releasing then pressing at 12 ms gives oTimeMs=12.
- Abort and reset mid-round:
  - Stimulus: iAbort in GO.
  - Required: IDLE next cycle, oGo=0, no oDone.
  - Stimulus: async iReset mid-WAIT.
  - Required: all outputs 0 without waiting for a clock edge.
- Restart from RESULT:
  - Stimulus: iStart pulse in RESULT.
  - Required: ARM next cycle, flags cleared, new delay drawn from the current LFSR value.

Source files
------------

// File: rtl/reaction_round_fsm_pkg.sv
// rtl/reaction_round_fsm_pkg.sv - shared encodings for the reaction-time round and its neighbours
package reaction_round_fsm_pkg;

  // Round states; the display mux decodes these directly.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ARM    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_GO     = 3'd3,
    ST_RESULT = 3'd4
  } state_t;

  // Main menu selection codes.
  localparam logic [1:0] MENU_MENU  = 2'b00;
  localparam logic [1:0] MENU_REACT = 2'b01;
  localparam logic [1:0] MENU_CHIMP = 2'b10;

  // Millisecond result width; 9999 fits a four-digit display.
  localparam int unsigned RESULT_W = 14;

  // One step of the 16-bit Fibonacci LFSR, taps 16,14,13,11.
  function automatic logic [15:0] lfsr16_next(input logic [15:0] value);
    return {value[14:0], value[15] ^ value[13] ^ value[12] ^ value[10]};
  endfunction

endpackage

// File: rtl/reaction_round_fsm_lfsr16.sv
// rtl/reaction_round_fsm_lfsr16.sv - free-running 16-bit LFSR, also used by the chimp test
module lfsr16
  import reaction_round_fsm_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        iClock,
  input  logic        iReset,
  output logic [15:0] oValue
);

  logic [15:0] lfsr_q;

  // A zero seed would lock the register at zero forever.
  if (SEED == 16'h0000) begin : g_seed_check
    $error("lfsr16: SEED must be nonzero");
  end

  // Step every cycle from reset; a maximal-length sequence never reaches zero.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr16_next(lfsr_q);
    end
  end

  assign oValue = lfsr_q;

endmodule

// File: rtl/reaction_round_fsm.sv
// rtl/reaction_round_fsm.sv - one round of the reaction-time test: random wait, go, timed press
module reaction_round_fsm
  import reaction_round_fsm_pkg::*;
#(
  parameter int unsigned CLK_HZ       = 50000000,
  parameter int unsigned MIN_DELAY_MS = 1000,
  parameter int unsigned DELAY_BITS   = 11,
  parameter int unsigned TIMEOUT_MS   = 9999,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                iClock,
  input  logic                iReset,
  input  logic                iStart,
  input  logic                iAbort,
  input  logic                iPress,
  output logic [2:0]          oState,
  output logic                oGo,
  output logic [RESULT_W-1:0] oTimeMs,
  output logic                oDone,
  output logic                oEarly,
  output logic                oTimeout,
  output logic                oBusy
);

  localparam int unsigned MS_TICKS = CLK_HZ / 1000;
  localparam int unsigned PRESC_W  = (MS_TICKS > 1) ? $clog2(MS_TICKS) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(MS_TICKS - 1);
  localparam logic [RESULT_W-1:0] MIN_DELAY  = RESULT_W'(MIN_DELAY_MS);
  localparam logic [RESULT_W-1:0] TIMEOUT    = RESULT_W'(TIMEOUT_MS);

  // Parameter sanity: the longest delay and the timeout must fit the result width.
  if (MIN_DELAY_MS + (2 ** DELAY_BITS) - 1 >= (2 ** RESULT_W)) begin : g_delay_check
    $error("reaction_round_fsm: MIN_DELAY_MS + 2**DELAY_BITS - 1 does not fit 14 bits");
  end
  if (TIMEOUT_MS >= (2 ** RESULT_W)) begin : g_timeout_check
    $error("reaction_round_fsm: TIMEOUT_MS does not fit 14 bits");
  end
  if (MS_TICKS == 0) begin : g_tick_check
    $error("reaction_round_fsm: CLK_HZ must be at least 1000");
  end
  if (DELAY_BITS == 0 || DELAY_BITS > 16) begin : g_bits_check
    $error("reaction_round_fsm: DELAY_BITS must be 1..16");
  end

  state_t              state_q;
  logic                press_q;
  logic                press_ev;
  logic [PRESC_W-1:0]  presc_q;
  logic [PRESC_W-1:0]  presc_d;
  logic [RESULT_W-1:0] ms_q;
  logic [RESULT_W-1:0] ms_d;
  logic [RESULT_W-1:0] delay_q;
  logic [RESULT_W-1:0] time_q;
  logic                go_q;
  logic                done_q;
  logic                early_q;
  logic                timeout_q;
  logic                busy_q;
  logic                ms_wrap;
  logic [15:0]         lfsr_value;
  logic                unused_lfsr_bits;

  lfsr16 #(
    .SEED   (LFSR_SEED)
  ) u_lfsr (
    .iClock (iClock),
    .iReset (iReset),
    .oValue (lfsr_value)
  );

  // Only the low DELAY_BITS feed the delay here; the rest go to other consumers.
  assign unused_lfsr_bits = ^lfsr_value;

  // Register the button every cycle so only rising edges count as presses.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      press_q <= 1'b0;
    end else begin
      press_q <= iPress;
    end
  end

  assign press_ev = iPress & ~press_q;

  // Millisecond timebase: prescaler wraps every MS_TICKS clocks and bumps the ms count.
  assign ms_wrap = (presc_q == PRESC_LAST);
  assign presc_d = ms_wrap ? '0 : presc_q + PRESC_W'(1);
  assign ms_d    = ms_wrap ? ms_q + RESULT_W'(1) : ms_q;

  // Round sequencer with registered outputs; abort and reset override everything.
  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state_q   <= ST_IDLE;
      presc_q   <= '0;
      ms_q      <= '0;
      delay_q   <= '0;
      time_q    <= '0;
      go_q      <= 1'b0;
      done_q    <= 1'b0;
      early_q   <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (iAbort) begin
        state_q   <= ST_IDLE;
        time_q    <= '0;
        go_q      <= 1'b0;
        early_q   <= 1'b0;
        timeout_q <= 1'b0;
        busy_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            time_q    <= '0;
            early_q   <= 1'b0;
            timeout_q <= 1'b0;
            if (iStart) begin
              state_q <= ST_ARM;
              busy_q  <= 1'b1;
            end
          end

          ST_ARM: begin
            delay_q <= MIN_DELAY + RESULT_W'(lfsr_value[DELAY_BITS-1:0]);
            presc_q <= '0;
            ms_q    <= '0;
            state_q <= ST_WAIT;
          end

          ST_WAIT: begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
            if (press_ev) begin
              // Jumped the gun: report an early press with no time.
              state_q <= ST_RESULT;
              early_q <= 1'b1;
              time_q  <= '0;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else if (ms_q == delay_q) begin
              state_q <= ST_GO;
              presc_q <= '0;
              ms_q    <= '0;
              go_q    <= 1'b1;
            end
          end

          ST_GO: begin
            presc_q <= presc_d;
            ms_q    <= ms_d;
            if (press_ev) begin
              // Completed milliseconds only; a press on the timeout cycle still counts.
              state_q <= ST_RESULT;
              time_q  <= ms_q;
              done_q  <= 1'b1;
              go_q    <= 1'b0;
              busy_q  <= 1'b0;
            end else if (ms_q == TIMEOUT) begin
              state_q   <= ST_RESULT;
              timeout_q <= 1'b1;
              time_q    <= TIMEOUT;
              done_q    <= 1'b1;
              go_q      <= 1'b0;
              busy_q    <= 1'b0;
            end
          end

          ST_RESULT: begin
            // Hold the result; a fresh start re-arms directly without visiting IDLE.
            if (iStart) begin
              state_q   <= ST_ARM;
              early_q   <= 1'b0;
              timeout_q <= 1'b0;
              busy_q    <= 1'b1;
            end
          end

          default: begin
            state_q <= ST_IDLE;
            go_q    <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign oState   = state_q;
  assign oGo      = go_q;
  assign oTimeMs  = time_q;
  assign oDone    = done_q;
  assign oEarly   = early_q;
  assign oTimeout = timeout_q;
  assign oBusy    = busy_q;

endmodule

// File: tb/tb_reaction_round_fsm.sv
// tb/tb_reaction_round_fsm.sv - directed scoreboard bench for reaction_round_fsm
module tb_reaction_round_fsm;
  import reaction_round_fsm_pkg::*;

  localparam int          CLK_HZ = 10000;
  localparam int          MS     = CLK_HZ / 1000;
  localparam int          MIN_MS = 5;
  localparam int          DBITS  = 2;
  localparam int          TO_MS  = 20;
  localparam logic [15:0] SEED   = 16'hACE1;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic        press;
  logic [2:0]  st;
  logic        go;
  logic [13:0] time_ms;
  logic        done;
  logic        early;
  logic        tmo;
  logic        busy;

  typedef struct {
    int   t;
    logic e;
    logic to;
  } exp_t;

  exp_t        sb[$];
  int          total;
  int          passed;
  int          failed;
  int          done_cnt;
  logic        go_seen;
  logic [15:0] m_lfsr;

  reaction_round_fsm #(
    .CLK_HZ       (CLK_HZ),
    .MIN_DELAY_MS (MIN_MS),
    .DELAY_BITS   (DBITS),
    .TIMEOUT_MS   (TO_MS),
    .LFSR_SEED    (SEED)
  ) dut (
    .iClock   (clk),
    .iReset   (rst),
    .iStart   (start),
    .iAbort   (abort),
    .iPress   (press),
    .oState   (st),
    .oGo      (go),
    .oTimeMs  (time_ms),
    .oDone    (done),
    .oEarly   (early),
    .oTimeout (tmo),
    .oBusy    (busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [15:0] step(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction

  // Reference LFSR stepping alongside the DUT from the same reset.
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= SEED;
    else     m_lfsr <= step(m_lfsr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int t, input logic e, input logic to);
    exp_t x;
    x.t = t;
    x.e = e;
    x.to = to;
    sb.push_back(x);
  endtask

  // Pulse start on the current low phase; return the delay the ARM cycle will draw.
  task automatic start_round(output int dly);
    logic [15:0] v;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    v = m_lfsr;
    dly = MIN_MS + int'(v[DBITS-1:0]);
    check("arm_state", st, ST_ARM);
    check("arm_busy", busy, 1);
  endtask

  task automatic wait_go(output int n);
    n = 0;
    while (go !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Result monitor: every done pulse pops one expected result.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (go === 1'b1) go_seen = 1'b1;
      if (done === 1'b1) begin
        done_cnt++;
        if (sb.size() == 0) begin
          check("done_with_empty_scoreboard", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          check("sb_time_ms", time_ms, e.t);
          check("sb_early", early, e.e);
          check("sb_timeout", tmo, e.to);
        end
      end
    end
  end

  initial begin
    int          d;
    int          n;
    int          m;
    int          dc;
    logic [15:0] nxt;
    total = 0; passed = 0; failed = 0; done_cnt = 0; go_seen = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; press = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {st, go, time_ms, done, early, tmo, busy}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", {st, busy}, {ST_IDLE, 1'b0});

    // Normal round: start when the ARM cycle will see LFSR low bits == 2 (7 ms).
    for (int i = 0; i < 200; i++) begin
      nxt = step(m_lfsr);
      if (nxt[1:0] == 2'd2) break;
      @(negedge clk);
    end
    start_round(d);
    check("normal_delay_ms", d, 7);
    wait_go(n);
    // 1 ARM edge, 7*MS counting WAIT edges, 1 edge seeing msCnt==delay.
    check("normal_go_latency", n, d * MS + 2);
    repeat (35) @(negedge clk);
    push(3, 1'b0, 1'b0);
    press = 1'b1;
    @(negedge clk);
    check("normal_result_state", st, ST_RESULT);
    check("normal_outs", {go, busy, early, tmo}, 0);
    press = 1'b0;
    @(negedge clk);
    check("normal_done_single", done, 0);
    check("normal_time_held", time_ms, 3);

    // Abort out of RESULT, then an early press 20 clocks into WAIT.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_result_idle", {st, time_ms}, {ST_IDLE, 14'd0});
    go_seen = 1'b0;
    start_round(d);
    @(negedge clk);
    check("early_in_wait", st, ST_WAIT);
    repeat (20) @(negedge clk);
    push(0, 1'b1, 1'b0);
    press = 1'b1;
    @(negedge clk);
    check("early_result_state", st, ST_RESULT);
    press = 1'b0;
    repeat (3) @(negedge clk);
    check("early_go_never", go_seen, 0);
    check("early_flag_held", early, 1);

    // Restart from RESULT straight into ARM, then let it time out.
    start_round(d);
    check("restart_flags_clear", {early, tmo}, 0);
    wait_go(n);
    check("restart_go_latency", n, d * MS + 2);
    push(TO_MS, 1'b0, 1'b1);
    m = 0;
    while (done !== 1'b1 && m < 1000) begin
      @(negedge clk);
      m++;
    end
    check("timeout_latency", m, TO_MS * MS + 1);
    @(negedge clk);
    check("timeout_held", {st, tmo, done, go}, {ST_RESULT, 1'b1, 1'b0, 1'b0});

    // Held button across GO entry must not count; release then press at 12 ms.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    press = 1'b1;
    repeat (3) @(negedge clk);
    start_round(d);
    wait_go(n);
    check("held_go_latency", n, d * MS + 2);
    check("held_no_early", early, 0);
    repeat (50) @(negedge clk);
    check("held_still_go", st, ST_GO);
    press = 1'b0;
    repeat (75) @(negedge clk);
    push(12, 1'b0, 1'b0);
    press = 1'b1;
    @(negedge clk);
    check("held_result_state", st, ST_RESULT);
    press = 1'b0;
    @(negedge clk);

    // Abort while in GO.
    start_round(d);
    wait_go(n);
    repeat (5) @(negedge clk);
    dc = done_cnt;
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("abort_go_idle", {st, go, busy}, {ST_IDLE, 1'b0, 1'b0});
    repeat (5) @(negedge clk);
    check("abort_no_done", done_cnt, dc);

    // Asynchronous reset in the middle of WAIT.
    start_round(d);
    repeat (30) @(negedge clk);
    check("mid_wait_state", st, ST_WAIT);
    #2 rst = 1'b1;
    #1;
    check("async_reset_outputs", {st, go, time_ms, done, early, tmo, busy}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_stays_idle", st, ST_IDLE);
    check("total_done_pulses", done_cnt, 4);
    check("scoreboard_drained", sb.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
